// File: rtl/bus_initiator_if.sv
// Bundles the core command/response signals and the shared-bus request/grant signals
// seen by one bus_initiator. The master modport is the initiator's view; the slave
// modport is the environment's (core datapath plus arbiter/bus) view.
interface bus_initiator_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);

  // Core command / response side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Shared bus side
  logic              grant_request;
  logic              grant_given;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, grant_given, data_in,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, grant_request, rw, address, data_out
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, grant_given, data_in,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, grant_request, rw, address, data_out
  );

endinterface

// File: rtl/bus_initiator.sv
// Core-side master port for the shared system bus. Accepts one command at a time,
// requests the bus, performs a single-cycle access, waits RD_LATENCY cycles for read
// data, then releases the bus for one cycle while pulsing the response.
//
// Optional feature: define BUS_INITIATOR_TIMEOUT_EN to abort a request that has not
// been granted within TIMEOUT_CYCLES cycles (completes with rsp_err = 1). Without it
// the request waits indefinitely and rsp_err is always 0.
//
// RD_LATENCY must be 1..15; TIMEOUT_CYCLES must be at least 1.
module bus_initiator #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      reset,
  bus_initiator_if.master bus
);

  localparam logic [3:0] LatInit = 4'(RD_LATENCY);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAccess,
    StWaitRd,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_q, lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // High in the REQ cycle in which the grant wait limit expires without a grant.
  logic timeout;
  // Marks the current completion as a timeout abort.
  logic err_flag;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned WaitW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  assign timeout  = (state_q == StReq) && !bus.grant_given && (wait_q >= WaitLast);
  assign err_flag = err_q;

  // Wait counter: held at zero outside REQ so every entry into REQ starts a fresh count.
  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if (state_q != StReq) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + WaitW'(1);
      // Leaving REQ decides whether this transaction completes as an abort.
      err_d  = timeout;
    end
  end

  // Wait counter and abort flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  // TIMEOUT_CYCLES has no effect in this build; the grant wait is unbounded.
  assign timeout  = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign err_flag = 1'b0;
`endif

  // Next-state logic: command latch, grant handshake, read latency countdown.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          rw_d    = bus.cmd_rw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          state_d = StReq;
        end
      end

      StReq: begin
        if (bus.grant_given) begin
          state_d = StAccess;
        end else if (timeout) begin
          state_d = StRelease;
        end
      end

      StAccess: begin
        // Losing the grant here means the access did not take effect; retry it.
        if (!bus.grant_given) begin
          state_d = StReq;
        end else if (rw_q) begin
          state_d = StRelease;
        end else begin
          lat_d   = LatInit;
          state_d = StWaitRd;
        end
      end

      StWaitRd: begin
        if (!bus.grant_given) begin
          state_d = StReq;
        end else begin
          lat_d = lat_q - 4'd1;
          if (lat_d == 4'd0) begin
            rdata_d = bus.data_in;
            state_d = StRelease;
          end
        end
      end

      StRelease: begin
        rw_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decoded from state so reset takes them low immediately.
  logic holding_bus;
  assign holding_bus = (state_q == StReq) || (state_q == StAccess) || (state_q == StWaitRd);

  assign bus.cmd_ready     = reset && (state_q == StIdle);
  assign bus.grant_request = holding_bus;
  // rw only in ACCESS: exactly one write strobe per granted attempt.
  assign bus.rw            = (state_q == StAccess) && rw_q;
  assign bus.address       = holding_bus ? addr_q : '0;
  assign bus.data_out      = holding_bus ? wdata_q : '0;
  assign bus.rsp_valid     = (state_q == StRelease);
  assign bus.rsp_err       = (state_q == StRelease) && err_flag;
  assign bus.rsp_rdata     = rdata_q;

endmodule
